booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq.sv | 137 +++++++++++++
 tb/tb_booth_mult_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Iterative Booth multiplier, signed/unsigned at run time, start/busy/done handshake.
// Build option: define BOOTH_RADIX4_EN for radix-4 modified Booth steps (fewer cycles, same products).
module booth_mult_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned E  = WIDTH + 2;
    localparam int unsigned PW = 2 * WIDTH;
`ifdef BOOTH_RADIX4_EN
    localparam int unsigned AW     = E + 1;
    localparam int unsigned NSTEPS = E / 2;
`else
    localparam int unsigned AW     = E;
    localparam int unsigned NSTEPS = E - 1;
`endif
    localparam int unsigned CW = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         state;
    logic [AW-1:0]  acc;
    logic [E-1:0]   qx;
    logic           q_1;
    logic [E-1:0]   mx;
    logic [CW-1:0]  cnt;

    logic [AW-1:0]  sum;
    logic [AW-1:0]  acc_nxt;
    logic [E-1:0]   qx_nxt;
    logic           q1_nxt;
    logic [PW-1:0]  prod_nxt;

    // Two extra bits let one signed datapath cover the full unsigned range too.
    function automatic logic [E-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
        return {{2{sgn & v[WIDTH-1]}}, v};
    endfunction

`ifdef BOOTH_RADIX4_EN
    logic [AW-1:0] mx_a;
    logic [AW-1:0] mx2;

    // Radix-4 step: recode {Qx[1:0], q_1} into 0, +-M, +-2M, then shift by 2.
    always_comb begin
        mx_a = {mx[E-1], mx};
        mx2  = {mx, 1'b0};
        sum  = acc;
        case ({qx[1], qx[0], q_1})
            3'b001, 3'b010: sum = acc + mx_a;
            3'b011:         sum = acc + mx2;
            3'b100:         sum = acc - mx2;
            3'b101, 3'b110: sum = acc - mx_a;
            default:        sum = acc;
        endcase
        acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        qx_nxt   = {sum[1:0], qx[E-1:2]};
        q1_nxt   = qx[1];
        prod_nxt = {acc_nxt[WIDTH-3:0], qx_nxt};
    end
`else
    // Radix-2 step: add/subtract on {Qx[0], q_1}, then shift by 1.
    always_comb begin
        sum = acc;
        case ({qx[0], q_1})
            2'b01:   sum = acc + mx;
            2'b10:   sum = acc - mx;
            default: sum = acc;
        endcase
        acc_nxt  = {sum[AW-1], sum[AW-1:1]};
        qx_nxt   = {sum[0], qx[E-1:1]};
        q1_nxt   = qx[0];
        // After E-1 steps the product sits one bit above the bottom of {A, Qx}.
        prod_nxt = {acc_nxt[WIDTH-2:0], qx_nxt[E-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            qx      <= '0;
            q_1     <= 1'b0;
            mx      <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        qx    <= ext(Q, signed_mode);
                        q_1   <= 1'b0;
                        mx    <= ext(M, signed_mode);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    qx  <= qx_nxt;
                    q_1 <= q1_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NSTEPS - 1)) begin
                        product <= prod_nxt;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_FIN;
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed corner products, handshake/abort cases, random pairs.
module tb_booth_mult_seq;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 2 * W;
`ifdef BOOTH_RADIX4_EN
    localparam int unsigned LAT = (W + 2) / 2;
`else
    localparam int unsigned LAT = W + 1;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  M;
    logic [W-1:0]  Q;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .M           (M),
        .Q           (Q),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q);
        longint a;
        longint b;
        if (sm) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        return PW'(a * b);
    endfunction

    // Drive one start pulse; operands are scrambled right after the sampling edge.
    task automatic issue(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [PW-1:0] exp);
        @(negedge clk);
        signed_mode = sm;
        M = m;
        Q = q;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        M = W'($urandom);
        Q = W'($urandom);
        signed_mode = ~sm;
        exp_q.push_back(exp);
    endtask

    task automatic wait_result(input string tag, input int cyc0);
        int cyc;
        logic [PW-1:0] e;
        cyc = cyc0;
        while (!done && cyc < 4 * int'(LAT)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
        e = exp_q.pop_front();
        chk({tag, "_prod"}, 64'(product), 64'(e));
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    task automatic run_one(input string tag, input logic sm, input logic [W-1:0] m,
                           input logic [W-1:0] q, input logic [PW-1:0] exp);
        issue(sm, m, q, exp);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_result(tag, 0);
    endtask

    initial begin
        logic [W-1:0] rm;
        logic [W-1:0] rq;
        int cyc;

        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        M = '0;
        Q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_one("s_18x999",   1'b1, 16'd18,    16'd999,   32'h0000463E);
        run_one("s_neg",      1'b1, 16'hF6F9,  16'd11111, 32'hFE78312F);
        run_one("s_m1m1",     1'b1, 16'hFFFF,  16'hFFFF,  32'h00000001);
        run_one("s_maxmax",   1'b1, 16'h7FFF,  16'h7FFF,  32'h3FFF0001);
        run_one("s_minmin",   1'b1, 16'h8000,  16'h8000,  32'h40000000);
        run_one("s_zero",     1'b1, 16'h0000,  16'h9ABC,  32'h00000000);
        run_one("u_ffff",     1'b0, 16'hFFFF,  16'hFFFF,  32'hFFFE0001);
        run_one("u_8000",     1'b0, 16'h8000,  16'h8000,  32'h40000000);
        run_one("u_14234",    1'b0, 16'd14234, 16'd14244, 32'd202749096);
        run_one("u_zero",     1'b0, 16'hFFFF,  16'h0000,  32'h00000000);

        // Second start mid-run must be ignored.
        issue(1'b0, 16'd3, 16'd5, 32'd15);
        chk("ign_busy", 64'(busy), 64'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        M = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result("ign", 5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("ign_idle_done", 64'(done), 64'd0);
            chk("ign_idle_busy", 64'(busy), 64'd0);
            chk("ign_idle_prod", 64'(product), 64'd15);
        end

        // Reset in the middle of a multiply aborts it.
        issue(1'b1, 16'd100, 16'd100, 32'd10000);
        void'(exp_q.pop_front());
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one("after_abort", 1'b1, 16'd2, 16'hFFFD, 32'hFFFFFFFA);

        // Random pairs against the reference multiply, both modes.
        for (int mode = 0; mode < 2; mode++) begin
            for (int n = 0; n < 1000; n++) begin
                rm = W'($urandom);
                rq = W'($urandom);
                if (n % 50 == 0) rm = 16'h8000;
                if (n % 70 == 0) rq = 16'hFFFF;
                issue(mode[0], rm, rq, model(mode[0], rm, rq));
                cyc = 0;
                wait_result(mode == 0 ? "rnd_u" : "rnd_s", cyc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
